// File: rtl/match_vector_unit.sv
// Match-vector unit: collects a frame of CAM match vectors, derives per-group and
// frame-wide MSB masks, then streams each stored vector ORed with its selected mask.
module match_vector_unit #(
  parameter int CAM_LEN    = 32,
  parameter int GROUP_LEN  = 16,
  parameter int NUM_GROUPS = 4,
  localparam int GW        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic               mv_valid,
  input  logic [CAM_LEN-1:0] mv_in,
  output logic               mv_ready,
  output logic               sub_valid,
  input  logic               sub_ready,
  output logic [CAM_LEN-1:0] sub_vector,
  output logic [GW-1:0]      sub_group,
  output logic               busy,
  output logic               done
);

  localparam int TOTAL  = GROUP_LEN * NUM_GROUPS;
  localparam int CW     = $clog2(TOTAL);
  localparam int GL_W   = $clog2(GROUP_LEN);
  localparam int NG_PAD = 1 << GW;

  typedef enum logic [2:0] {IDLE, COLLECT, MAXCALC, EMIT, DONE} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [GW-1:0]      grp_q, grp_d;
  logic [CAM_LEN-1:0] buffer_q [TOTAL];
  logic [CAM_LEN-1:0] buffer_d [TOTAL];
  // Group-indexed arrays are padded to a power of two so a GW-bit index always fits.
  logic [CAM_LEN-1:0] or_buf_q [NG_PAD];
  logic [CAM_LEN-1:0] or_buf_d [NG_PAD];
  logic [CAM_LEN-1:0] local_max_q [NG_PAD];
  logic [CAM_LEN-1:0] local_max_d [NG_PAD];
  logic [CAM_LEN-1:0] or_all_q, or_all_d;
  logic [CAM_LEN-1:0] global_max_q, global_max_d;
  logic [GW-1:0]      cnt_grp;

  function automatic logic [CAM_LEN-1:0] msb_onehot(input logic [CAM_LEN-1:0] v);
    logic [CAM_LEN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < CAM_LEN; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb cnt_grp = GW'(cnt_q >> GL_W);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    grp_d        = grp_q;
    buffer_d     = buffer_q;
    or_buf_d     = or_buf_q;
    local_max_d  = local_max_q;
    or_all_d     = or_all_q;
    global_max_d = global_max_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = COLLECT;
          mode_d   = mode;
          cnt_d    = '0;
          or_buf_d = '{default: '0};
        end
      end
      COLLECT: begin
        if (mv_valid) begin
          buffer_d[cnt_q]   = mv_in;
          or_buf_d[cnt_grp] = or_buf_q[cnt_grp] | mv_in;
          if (cnt_q == CW'(TOTAL - 1)) begin
            state_d  = MAXCALC;
            cnt_d    = '0;
            grp_d    = '0;
            or_all_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      MAXCALC: begin
        local_max_d[grp_q] = msb_onehot(or_buf_q[grp_q]);
        or_all_d           = or_all_q | or_buf_q[grp_q];
        if (grp_q == GW'(NUM_GROUPS - 1)) begin
          global_max_d = msb_onehot(or_all_q | or_buf_q[grp_q]);
          state_d      = EMIT;
          cnt_d        = '0;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      EMIT: begin
        if (sub_ready) begin
          if (cnt_q == CW'(TOTAL - 1)) state_d = DONE;
          else                          cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      cnt_q        <= '0;
      grp_q        <= '0;
      buffer_q     <= '{default: '0};
      or_buf_q     <= '{default: '0};
      local_max_q  <= '{default: '0};
      or_all_q     <= '0;
      global_max_q <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      grp_q        <= grp_d;
      buffer_q     <= buffer_d;
      or_buf_q     <= or_buf_d;
      local_max_q  <= local_max_d;
      or_all_q     <= or_all_d;
      global_max_q <= global_max_d;
    end
  end

  // Outputs decode the state flop; reset gating keeps them at zero while reset is held low.
  always_comb begin
    mv_ready   = reset && (state_q == COLLECT);
    sub_valid  = reset && (state_q == EMIT);
    busy       = reset && (state_q != IDLE);
    done       = reset && (state_q == DONE);
    sub_vector = '0;
    sub_group  = '0;
    if (sub_valid) begin
      sub_vector = buffer_q[cnt_q] | (mode_q ? global_max_q : local_max_q[cnt_grp]);
      sub_group  = cnt_grp;
    end
  end

endmodule

// File: tb/tb_match_vector_unit.sv
// Bench for match_vector_unit: frame-level reference model, per-cycle output compare,
// directed frames plus a reduced-size instance.
module tb_match_vector_unit;

  logic        clk = 1'b0;
  logic        reset, start, mode, mv_valid, sub_ready;
  logic [31:0] mv_in;
  logic        mv_ready, sub_valid, busy, done;
  logic [31:0] sub_vector;
  logic [1:0]  sub_group;

  logic       s_start, s_mv_valid;
  logic [7:0] s_mv_in;
  logic       s_mv_ready, s_sub_valid, s_busy, s_done;
  logic [7:0] s_sub_vector;
  logic [0:0] s_sub_group;

  int checks   = 0;
  int failures = 0;

  logic [31:0] in_v  [64];
  logic [31:0] exp_v [64];
  int          exp_g [64];
  logic [31:0] rec_v [64];
  int          emit_idx = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  match_vector_unit #(.CAM_LEN(32), .GROUP_LEN(16), .NUM_GROUPS(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .mv_valid(mv_valid), .mv_in(mv_in), .mv_ready(mv_ready),
    .sub_valid(sub_valid), .sub_ready(sub_ready), .sub_vector(sub_vector),
    .sub_group(sub_group), .busy(busy), .done(done)
  );

  match_vector_unit #(.CAM_LEN(8), .GROUP_LEN(2), .NUM_GROUPS(1)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .mode(1'b0),
    .mv_valid(s_mv_valid), .mv_in(s_mv_in), .mv_ready(s_mv_ready),
    .sub_valid(s_sub_valid), .sub_ready(1'b1), .sub_vector(s_sub_vector),
    .sub_group(s_sub_group), .busy(s_busy), .done(s_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Highest set bit as a power of two, via ceil-log2 of (x+1) in 64-bit arithmetic.
  function automatic logic [31:0] top_bit(input logic [31:0] x);
    logic [63:0] x64;
    x64 = {32'd0, x};
    if (x == 32'd0) return 32'd0;
    return 32'(64'd1 << ($clog2(x64 + 64'd1) - 1));
  endfunction

  task automatic build_model(input logic m);
    logic [31:0] grp_or [4];
    logic [31:0] all_or;
    all_or = 32'd0;
    for (int g = 0; g < 4; g++) begin
      grp_or[g] = 32'd0;
      for (int j = 0; j < 16; j++) grp_or[g] |= in_v[g*16 + j];
      all_or |= grp_or[g];
    end
    for (int k = 0; k < 64; k++) begin
      exp_v[k] = in_v[k] | (m ? top_bit(all_or) : top_bit(grp_or[k/16]));
      exp_g[k] = k / 16;
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("reset_outputs", {26'd0, mv_ready, sub_valid, busy, done, sub_group, sub_vector}, 64'd0);
    end else begin
      if (sub_valid) begin
        if (emit_idx >= 64) begin
          check("emit_overflow", 64'(emit_idx), 64'd63);
        end else begin
          check("sub_vector", {32'd0, sub_vector}, {32'd0, exp_v[emit_idx]});
          check("sub_group", {62'd0, sub_group}, 64'(exp_g[emit_idx]));
          if (sub_ready) begin
            rec_v[emit_idx] = sub_vector;
            emit_idx++;
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_frame(input logic m, input int gap, input int stall);
    int cyc;
    build_model(m);
    emit_idx = 0;
    done_cnt = 0;
    start    = 1'b1;
    mode     = m;
    mv_valid = 1'b1;
    mv_in    = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        mv_valid = 1'b0;
        @(posedge clk); #1;
      end
      mv_valid = 1'b1;
      mv_in    = in_v[k];
      cyc      = 0;
      while (!mv_ready && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("mv_ready", {63'd0, mv_ready}, 64'd1);
      @(posedge clk); #1;
    end
    mv_valid = 1'b0;
    cyc      = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      sub_ready = (stall == 0) || ($urandom_range(99) >= stall);
      @(posedge clk); #1;
      cyc++;
    end
    sub_ready = 1'b1;
    check("done_count", 64'(done_cnt), 64'd1);
    check("emit_count", 64'(emit_idx), 64'd64);
    @(posedge clk); #1;
    check("idle_after_done", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    logic [7:0] s_rec [2];
    int         s_n;
    int         s_done_cnt;

    reset = 1'b0; start = 1'b0; mode = 1'b0; mv_valid = 1'b0; mv_in = '0; sub_ready = 1'b1;
    s_start = 1'b0; s_mv_valid = 1'b0; s_mv_in = '0;
    for (int k = 0; k < 64; k++) begin exp_v[k] = '0; exp_g[k] = 0; rec_v[k] = '0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {61'd0, mv_ready, busy, done}, 64'd0);

    // Local max, one distinct bit per group, no stalls
    for (int k = 0; k < 64; k++) in_v[k] = 32'd1 << (k/16 + 2);
    run_frame(1'b0, 0, 0);
    check("pin_t1_model0", {32'd0, exp_v[0]}, 64'h4);
    check("pin_t1_model63", {32'd0, exp_v[63]}, 64'h20);
    check("t1_out0", {32'd0, rec_v[0]}, 64'h4);
    check("t1_out40", {32'd0, rec_v[40]}, 64'h10);

    // Global max spreads group 0's bit31 to every output
    for (int k = 0; k < 64; k++) in_v[k] = (k < 16) ? 32'h8000_0000 : 32'h1;
    run_frame(1'b1, 0, 0);
    check("pin_t2_model16", {32'd0, exp_v[16]}, 64'h8000_0001);
    check("t2_out0", {32'd0, rec_v[0]}, 64'h8000_0000);
    check("t2_out63", {32'd0, rec_v[63]}, 64'h8000_0001);

    // All-zero frame, both modes
    for (int k = 0; k < 64; k++) in_v[k] = 32'd0;
    run_frame(1'b0, 0, 0);
    check("t3_out5", {32'd0, rec_v[5]}, 64'h0);
    run_frame(1'b1, 0, 0);

    // Random data with input gaps and output stalls
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 64; k++) in_v[k] = $urandom() >> $urandom_range(31);
      run_frame(r[0], 30, 40);
    end

    // Abort a frame after 20 transfers of all-ones, then run a clean frame
    emit_idx = 0; done_cnt = 0;
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mv_valid = 1'b1; mv_in = 32'hFFFF_FFFF;
    repeat (20) begin @(posedge clk); #1; end
    mv_valid = 1'b0;
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_no_emit", 64'(emit_idx), 64'd0);
    for (int k = 0; k < 64; k++) in_v[k] = 32'd1 << (k/16 + 2);
    run_frame(1'b1, 0, 0);
    check("t4_out0", {32'd0, rec_v[0]}, 64'h24);
    check("t4_out63", {32'd0, rec_v[63]}, 64'h20);

    // Reduced instance: 8-bit vectors, one group of two
    s_n = 0; s_done_cnt = 0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_mv_valid = 1'b1; s_mv_in = 8'h05;
    @(posedge clk); #1;
    s_mv_in = 8'h30;
    @(posedge clk); #1;
    s_mv_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s_sub_valid) begin
        check("small_group", {63'd0, s_sub_group}, 64'd0);
        if (s_n < 2) s_rec[s_n] = s_sub_vector;
        s_n++;
      end
      if (s_done) s_done_cnt++;
    end
    check("small_count", 64'(s_n), 64'd2);
    check("small_out0", {56'd0, s_rec[0]}, 64'h25);
    check("small_out1", {56'd0, s_rec[1]}, 64'h30);
    check("small_done", 64'(s_done_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/match_vector_unit.md
MATCH_VECTOR_UNIT -- requirements
Module: match_vector_unit

Interface
REQ-001 Parameter CAM_LEN, default 32: match-vector width in bits.
REQ-002 Parameter GROUP_LEN, default 16: vectors per group, a power of two and at least 2.
REQ-003 Parameter NUM_GROUPS, default 4: groups per frame, at least 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; asserted when low, sampled on the rising edge of clk.
REQ-006 start  input  1  one-cycle frame start request.
REQ-007 mode  input  1  max mode, sampled with start: 0 = per-group local max, 1 = frame global max.
REQ-008 mv_valid  input  1  input match vector valid.
REQ-009 mv_in  input  CAM_LEN  input match vector.
REQ-010 mv_ready  output  1  unit can accept mv_in.
REQ-011 sub_valid  output  1  sub_vector valid.
REQ-012 sub_ready  input  1  downstream accepts sub_vector.
REQ-013 sub_vector  output  CAM_LEN  stored vector ORed with the selected max vector.
REQ-014 sub_group  output  $clog2(NUM_GROUPS) bits, minimum 1  group index of sub_vector.
REQ-015 busy  output  1  FSM is not in IDLE.
REQ-016 done  output  1  one-cycle pulse when the frame completes.

Function
REQ-017 FSM states: IDLE, COLLECT, MAXCALC, EMIT, DONE.
REQ-018 IDLE -> COLLECT on start; mode is latched at that edge; start in any other state is ignored.
REQ-019 COLLECT: mv_ready=1; a vector transfers on mv_valid&&mv_ready; no transfer means no state change.
REQ-020 Transfer k (0-based, 0 to GROUP_LEN*NUM_GROUPS-1) writes buffer[k] and ORs into or_buf[k/GROUP_LEN]; or_buf is cleared on start.
REQ-021 On the final transfer the FSM moves to MAXCALC on the next cycle; mv_ready=0 outside COLLECT.
REQ-022 MAXCALC: one group per cycle, NUM_GROUPS cycles; local_max[g] = one-hot of the MSB set in or_buf[g], or zero when or_buf[g]==0.
REQ-023 global_max = one-hot of the MSB set in the OR of all or_buf, or zero when all are zero; it is valid on MAXCALC exit.
REQ-024 EMIT: vectors are emitted in write order; sub_vector = buffer[k] | (mode ? global_max : local_max[k/GROUP_LEN]); sub_group = k/GROUP_LEN.
REQ-025 sub_valid=1 throughout EMIT; k advances only on sub_valid&&sub_ready; sub_vector and sub_group hold stable while sub_ready=0.
REQ-026 Emit index k wraps from GROUP_LEN-1 to the next group with no bubble, giving one vector per cycle while sub_ready=1.
REQ-027 After the final handshake: DONE for one cycle with done=1, then IDLE.
REQ-028 busy=1 in every state except IDLE.
REQ-029 Counter widths are $clog2 of their range; no counter wraps silently beyond GROUP_LEN*NUM_GROUPS.
REQ-030 A simultaneous start and mv_valid in IDLE: start is taken and mv_valid is not accepted that cycle, since mv_ready=0.

Reset
REQ-031 reset low at a clock edge, in any state including mid-frame, forces IDLE.
REQ-032 During that reset: mv_ready=0, sub_valid=0, sub_vector=0, sub_group=0, busy=0, done=0.
REQ-033 During that reset: buffer, or_buf, local_max, global_max and all counters are cleared to 0.
REQ-034 A partial frame is discarded on reset; no done pulse is issued.

Verification
REQ-035 Defaults, mode=0, group g vectors = 1<<(g+2), sub_ready=1: 64 outputs; group g outputs = 1<<(g+2); done pulses once.
REQ-036 Defaults, mode=1, group 0 holds 0x8000_0000, all others 0x1: every output has bit31 set; group 0 outputs = 0x8000_0000, others = 0x8000_0001.
REQ-037 All-zero input frame: local and global max are 0; all 64 sub_vector = 0.
REQ-038 Random mv_valid gaps and sub_ready stalls: output order, data and count match the model; sub_vector stable during every stall.
REQ-039 reset low after 20 transfers, then a new frame: no done for the aborted frame; the new frame output is free of stale OR bits.
REQ-040 CAM_LEN=8, GROUP_LEN=2, NUM_GROUPS=1, vectors 0x05 and 0x30: local_max = 0x20; outputs 0x25 and 0x30.
